// File: rtl/dp_pkg.sv
// Shared encodings for the multi-cycle datapath: ALU codes, PC control,
// memory/writeback selects and the sequencer state type.
package dp_pkg;

  localparam logic [3:0] ALU_MOV = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_MOD = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;
  localparam logic [3:0] ALU_XOR = 4'd8;
  localparam logic [3:0] ALU_NOT = 4'd9;
  localparam logic [3:0] ALU_SHR = 4'd10;
  localparam logic [3:0] ALU_SHL = 4'd11;

  localparam logic [2:0] PC_INC = 3'd0;
  localparam logic [2:0] PC_EQ  = 3'd1;
  localparam logic [2:0] PC_LT  = 3'd2;
  localparam logic [2:0] PC_GT  = 3'd3;
  localparam logic [2:0] PC_NE  = 3'd4;
  localparam logic [2:0] PC_LE  = 3'd5;
  localparam logic [2:0] PC_GE  = 3'd6;
  localparam logic [2:0] PC_JMP = 3'd7;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_LOAD  = 2'd1;
  localparam logic [1:0] MEM_STORE = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_OPB  = 2'd1;
  localparam logic [1:0] WB_LOAD = 2'd2;
  localparam logic [1:0] WB_ONES = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_DIV  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/dp_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, exactly WIDTH cycles.
// A zero divisor falls out naturally as quotient all-ones, remainder = dividend.
module dp_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign shifted = {remainder, quotient[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};
  // done marks the cycle whose closing edge performs the final step
  assign done    = busy && (cnt == CW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      cnt         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (start) begin
      busy        <= 1'b1;
      cnt         <= CW'(WIDTH);
      dvs         <= divisor;
      quotient    <= dividend;
      remainder   <= '0;
      div_by_zero <= (divisor == '0);
    end else if (busy) begin
      if (!diff[WIDTH]) begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, ALU, iterative divider, RAM load/store
// port and PC, sequenced IDLE -> EXEC -> (DIV | MEM) -> WB.
module datapath_mc
  import dp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int MEM_AW = 10,
  parameter int IMM_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [3:0]               alucode,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] rs,
  input  logic [$clog2(NREGS)-1:0] rt,
  input  logic [IMM_W-1:0]         imm,
  input  logic                     im_sel,
  input  logic                     reg_we,
  input  logic [1:0]               mem_op,
  input  logic [1:0]               wb_sel,
  input  logic [2:0]               pc_ctrl,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic [WIDTH-1:0]         pc,
  output logic                     retire,
  output logic                     div_by_zero
);

  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];

  logic [3:0]       alu_q;
  logic [RW-1:0]    rd_q;
  logic [IMM_W-1:0] imm_q;
  logic             reg_we_q;
  logic [1:0]       mem_op_q;
  logic [1:0]       wb_sel_q;
  logic [2:0]       pc_ctrl_q;
  logic [WIDTH-1:0] a_q, b_q, t_q, wd_q, load_q;

  logic [WIDTH-1:0] b_in, simm, alu_res, wb_val, pc_next;
  logic             taken, is_div;
  logic             div_busy, div_done, div_dbz;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign instr_ready = (state == S_IDLE);
  assign b_in        = im_sel ? WIDTH'($signed(imm)) : regs[rt];
  assign simm        = WIDTH'($signed(imm_q));
  assign is_div      = (alu_q == ALU_DIV) || (alu_q == ALU_MOD);
  assign mem_wdata   = wd_q;

  dp_divider #(.WIDTH(WIDTH)) u_div (
    .clock       (clock),
    .reset       (reset),
    .start       (state == S_EXEC && is_div),
    .dividend    (a_q),
    .divisor     (b_q),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem),
    .div_by_zero (div_dbz)
  );

  always_comb begin
    alu_res = '1;
    case (alu_q)
      ALU_MOV: alu_res = a_q;
      ALU_ADD: alu_res = a_q + b_q;
      ALU_SUB: alu_res = a_q - b_q;
      ALU_MUL: alu_res = a_q * b_q;
      ALU_DIV: alu_res = div_quo;
      ALU_MOD: alu_res = div_rem;
      ALU_OR:  alu_res = a_q | b_q;
      ALU_AND: alu_res = a_q & b_q;
      ALU_XOR: alu_res = a_q ^ b_q;
      ALU_NOT: alu_res = ~a_q;
      ALU_SHR: alu_res = a_q >> b_q[SW-1:0];
      ALU_SHL: alu_res = a_q << b_q[SW-1:0];
      default: alu_res = '1;
    endcase
  end

  always_comb begin
    wb_val = '1;
    case (wb_sel_q)
      WB_ALU:  wb_val = alu_res;
      WB_OPB:  wb_val = b_q;
      WB_LOAD: wb_val = load_q;
      default: wb_val = '1;
    endcase
  end

  // branches compare against regs[rt] even when operand B is the immediate
  always_comb begin
    taken = 1'b0;
    case (pc_ctrl_q)
      PC_EQ:   taken = (a_q == t_q);
      PC_LT:   taken = (a_q <  t_q);
      PC_GT:   taken = (a_q >  t_q);
      PC_NE:   taken = (a_q != t_q);
      PC_LE:   taken = (a_q <= t_q);
      PC_GE:   taken = (a_q >= t_q);
      PC_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    pc_next = pc + (taken ? simm : WIDTH'(1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      retire      <= 1'b0;
      div_by_zero <= 1'b0;
      alu_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      reg_we_q    <= 1'b0;
      mem_op_q    <= '0;
      wb_sel_q    <= '0;
      pc_ctrl_q   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      t_q         <= '0;
      wd_q        <= '0;
      load_q      <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      mem_we      <= 1'b0;
      retire      <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          alu_q     <= alucode;
          rd_q      <= rd;
          imm_q     <= imm;
          reg_we_q  <= reg_we;
          mem_op_q  <= mem_op;
          wb_sel_q  <= wb_sel;
          pc_ctrl_q <= pc_ctrl;
          a_q       <= regs[rs];
          b_q       <= b_in;
          t_q       <= regs[rt];
          wd_q      <= regs[rd];
          // address goes out during EXEC so the RAM read lands by the end of MEM
          mem_addr  <= MEM_AW'(regs[rs] + b_in);
          state     <= S_EXEC;
        end
        S_EXEC: begin
          if (is_div) begin
            state <= S_DIV;
          end else if (mem_op_q == MEM_LOAD || mem_op_q == MEM_STORE) begin
            mem_we <= (mem_op_q == MEM_STORE);
            state  <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_DIV: if (div_done || !div_busy) state <= S_WB;
        S_MEM: begin
          if (mem_op_q == MEM_LOAD) load_q <= mem_rdata;
          state <= S_WB;
        end
        S_WB: begin
          if (reg_we_q) regs[rd_q] <= wb_val;
          pc          <= pc_next;
          retire      <= 1'b1;
          div_by_zero <= is_div && div_dbz;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
